la_capture: RTL and testbench

Trigger-and-capture stage of the logic analyzer, directly downstream of the 8051 `top` design. It samples the 8-bit `P1out` port every `clkin` cycle into a circular buffer and waits for a masked pattern trigger. It freezes a window of `DEPTH` samples around the trigger, with `pre_count` samples before it, then streams that window out oldest-first through a request/valid read port for the host interface.

---
 rtl/la_capture.sv | 213 +++++++++++++++++++++
 tb/tb_la_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/la_capture.sv
// Logic-analyzer trigger-and-capture stage: samples the probe bus into a circular
// buffer, freezes a DEPTH-sample window around a masked pattern trigger, then streams it out.
module la_capture #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clkin,
    input  logic          resetin,
    input  logic [7:0]    probe,
    input  logic          arm,
    input  logic [7:0]    trig_value,
    input  logic [7:0]    trig_mask,
    input  logic [AW-1:0] pre_count,
    input  logic          rd_req,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          rd_last,
    output logic [2:0]    state,
    output logic          triggered
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW-1:0] ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    ram_rdata_q;

    logic [7:0]    probe_q;
    logic [2:0]    state_q,      state_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] fill_cnt_q,   fill_cnt_d;
    logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [AW-1:0] rd_cnt_q,     rd_cnt_d;
    logic [AW-1:0] start_q,      start_d;
    logic [AW-1:0] pre_count_q,  pre_count_d;
    logic [7:0]    trig_value_q, trig_value_d;
    logic [7:0]    trig_mask_q,  trig_mask_d;
    logic          triggered_q,  triggered_d;
    logic          rd_fire_q;
    logic          rd_last_pend_q;
    logic          rd_valid_q;
    logic          rd_last_q;
    logic [7:0]    rd_data_q;

    logic          wr_en_s;
    logic          rd_fire_s;
    logic          match_s;
    logic [AW-1:0] trig_start_s;

    assign match_s      = ((probe_q ^ trig_value_q) & trig_mask_q) == 8'h00;
    assign trig_start_s = wr_ptr_q - pre_count_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        start_d      = start_q;
        pre_count_d  = pre_count_q;
        trig_value_d = trig_value_q;
        trig_mask_d  = trig_mask_q;
        triggered_d  = triggered_q;
        wr_en_s      = 1'b0;
        rd_fire_s    = 1'b0;

        // arm outranks every other event in the same cycle
        if (arm) begin
            pre_count_d  = pre_count;
            trig_value_d = trig_value;
            trig_mask_d  = trig_mask;
            wr_ptr_d     = ZERO;
            fill_cnt_d   = ZERO;
            rd_ptr_d     = ZERO;
            rd_cnt_d     = ZERO;
            triggered_d  = 1'b0;
            if (pre_count == ZERO) begin
                state_d = S_ARMED;
            end else begin
                state_d = S_FILL;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FILL: begin
                    wr_en_s    = 1'b1;
                    wr_ptr_d   = wr_ptr_q + ONE;
                    fill_cnt_d = fill_cnt_q + ONE;
                    if ((fill_cnt_q + ONE) == pre_count_q) begin
                        state_d = S_ARMED;
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_ARMED: begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (match_s) begin
                        start_d     = trig_start_s;
                        triggered_d = 1'b1;
                        // a full pre-trigger window leaves no room for post samples
                        if (pre_count_q == LAST_IDX) begin
                            state_d  = S_DONE;
                            rd_ptr_d = trig_start_s;
                        end else begin
                            state_d = S_POST;
                        end
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_POST: begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (wr_ptr_q == (start_q - ONE)) begin
                        state_d  = S_DONE;
                        rd_ptr_d = start_q;
                    end else begin
                        state_d = S_POST;
                    end
                end
                S_DONE: begin
                    if (rd_req) begin
                        rd_fire_s = 1'b1;
                        rd_ptr_d  = rd_ptr_q + ONE;
                        rd_cnt_d  = rd_cnt_q + ONE;
                        if (rd_cnt_q == LAST_IDX) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= probe_q;
        end
        if (rd_fire_s) begin
            ram_rdata_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clkin or negedge resetin) begin
        if (!resetin) begin
            probe_q        <= 8'h00;
            state_q        <= S_IDLE;
            wr_ptr_q       <= ZERO;
            fill_cnt_q     <= ZERO;
            rd_ptr_q       <= ZERO;
            rd_cnt_q       <= ZERO;
            start_q        <= ZERO;
            pre_count_q    <= ZERO;
            trig_value_q   <= 8'h00;
            trig_mask_q    <= 8'h00;
            triggered_q    <= 1'b0;
            rd_fire_q      <= 1'b0;
            rd_last_pend_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            rd_data_q      <= 8'h00;
        end else begin
            probe_q        <= probe;
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_cnt_q     <= fill_cnt_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_cnt_q       <= rd_cnt_d;
            start_q        <= start_d;
            pre_count_q    <= pre_count_d;
            trig_value_q   <= trig_value_d;
            trig_mask_q    <= trig_mask_d;
            triggered_q    <= triggered_d;
            rd_fire_q      <= rd_fire_s;
            rd_last_pend_q <= rd_fire_s && (rd_cnt_q == LAST_IDX);
            // second read stage: RAM output register feeds the host-facing register
            if (arm) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end else begin
                rd_valid_q <= rd_fire_q;
                rd_last_q  <= rd_last_pend_q;
                if (rd_fire_q) begin
                    rd_data_q <= ram_rdata_q;
                end
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign state     = state_q;
    assign triggered = triggered_q;

endmodule

// File: tb/tb_la_capture.sv
// Directed self-checking bench for la_capture (DEPTH=16): ramp stimulus, expected
// readout samples queued as requests are issued and popped as rd_valid arrives.
module tb_la_capture;

    logic       clkin;
    logic       resetin;
    logic [7:0] probe;
    logic       arm;
    logic [7:0] trig_value;
    logic [7:0] trig_mask;
    logic [3:0] pre_count;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_last;
    logic [2:0] state;
    logic       triggered;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic       ramp_en = 1'b0;
    logic       seen_post = 1'b0;

    la_capture #(.DEPTH(16), .AW(4)) dut (
        .clkin      (clkin),
        .resetin    (resetin),
        .probe      (probe),
        .arm        (arm),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .pre_count  (pre_count),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .state      (state),
        .triggered  (triggered)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: sample just after the edge, score any read beat, advance the ramp
    task automatic step();
        logic [8:0] e;
        @(posedge clkin);
        #1;
        if (state === 3'd3) seen_post = 1'b1;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rd_valid", {31'd0, rd_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", {24'd0, rd_data}, {24'd0, e[7:0]});
                chk("rd_last", {31'd0, rd_last}, {31'd0, e[8]});
            end
        end
        if (ramp_en) probe = probe + 8'd1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (state === s) break;
            step();
        end
        chk(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic do_arm(input logic [7:0] tv, input logic [7:0] tm, input logic [3:0] pc);
        trig_value = tv;
        trig_mask  = tm;
        pre_count  = pc;
        arm        = 1'b1;
        step();
        arm        = 1'b0;
        trig_value = ~tv;
        trig_mask  = 8'h00;
        pre_count  = 4'd7;
    endtask

    task automatic read_n(input logic [7:0] base, input int n);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = base + 8'(i);
            exp_q.push_back({(i == 15), v});
            rd_req = 1'b1;
            step();
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("sb_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] first;
        resetin    = 1'b0;
        probe      = 8'h00;
        arm        = 1'b0;
        trig_value = 8'h00;
        trig_mask  = 8'h00;
        pre_count  = 4'd0;
        rd_req     = 1'b0;

        // reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            @(posedge clkin);
            #1;
            chk("rst_state", {29'd0, state}, 32'd0);
            chk("rst_trig", {31'd0, triggered}, 32'd0);
            chk("rst_valid_last_data", {22'd0, rd_valid, rd_last, rd_data}, 32'd0);
            probe = 8'($urandom);
            arm   = ~arm;
        end
        arm     = 1'b0;
        resetin = 1'b1;
        ramp_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("idle_after_reset", {29'd0, state}, 32'd0);

        // ramp capture, trigger 0x40 with 4 pre-trigger samples
        probe = 8'h20;
        do_arm(8'h40, 8'hFF, 4'd4);
        chk("ramp_fill", {29'd0, state}, 32'd1);
        chk("ramp_trig_clear", {31'd0, triggered}, 32'd0);
        wait_state(3'd4, "ramp_done");
        chk("ramp_triggered", {31'd0, triggered}, 32'd1);
        read_n(8'h3C, 16);
        chk("ramp_idle", {29'd0, state}, 32'd0);
        chk("ramp_trig_held", {31'd0, triggered}, 32'd1);
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rd_req = 1'b0;
        step();

        // no pre-trigger, mask 0: first sample after arm triggers
        probe = 8'h90;
        first = probe;
        do_arm(8'h00, 8'h00, 4'd0);
        chk("nopre_fill_skipped", {29'd0, state}, 32'd2);
        step();
        chk("nopre_post", {29'd0, state}, 32'd3);
        chk("nopre_triggered", {31'd0, triggered}, 32'd1);
        wait_state(3'd4, "nopre_done");
        read_n(first, 16);

        // maximum pre-trigger: POST skipped
        probe = 8'h50;
        do_arm(8'h80, 8'hFF, 4'd15);
        seen_post = 1'b0;
        wait_state(3'd4, "maxpre_done");
        chk("maxpre_post_skipped", {31'd0, seen_post}, 32'd0);
        read_n(8'h71, 16);

        // re-arm during ARMED, then during DONE after a partial readout
        probe = 8'h00;
        do_arm(8'h20, 8'hFF, 4'd4);
        wait_state(3'd2, "rearm_armed");
        do_arm(8'h30, 8'hFF, 4'd4);
        chk("rearm1_fill", {29'd0, state}, 32'd1);
        chk("rearm1_trig_clear", {31'd0, triggered}, 32'd0);
        wait_state(3'd4, "rearm1_done");
        chk("rearm1_triggered", {31'd0, triggered}, 32'd1);
        read_n(8'h2C, 3);
        do_arm(8'h60, 8'hFF, 4'd4);
        chk("rearm2_fill", {29'd0, state}, 32'd1);
        chk("rearm2_trig_clear", {31'd0, triggered}, 32'd0);
        wait_state(3'd4, "rearm2_done");
        read_n(8'h5C, 16);

        // asynchronous reset in the middle of POST
        probe = 8'h00;
        do_arm(8'h10, 8'hFF, 4'd4);
        wait_state(3'd3, "abort_post");
        step();
        #2;
        resetin = 1'b0;
        #1;
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_trig", {31'd0, triggered}, 32'd0);
        chk("abort_valid_last_data", {22'd0, rd_valid, rd_last, rd_data}, 32'd0);
        step();
        resetin = 1'b1;
        rd_req  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rd_req = 1'b0;
        step();
        chk("abort_idle", {29'd0, state}, 32'd0);
        chk("abort_no_data", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
